// File: rtl/noc_vc_link_buffer_if.sv
// Flit link bundle: shared flit bus with per-VC valid/ready.
interface noc_vc_link_buffer_if #(
    parameter int FW  = 34,
    parameter int VCH = 3
);
    logic [FW-1:0]  flit;
    logic [VCH-1:0] valid;
    logic [VCH-1:0] ready;

    modport master (output flit, output valid, input ready);
    modport slave  (input flit, input valid, output ready);
endinterface

// File: rtl/noc_vc_link_buffer.sv
// Virtual-channel link buffer: one flit FIFO per VC and a
// round-robin arbiter onto the shared downstream flit bus.
module noc_vc_link_buffer #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int VCHANNELS       = 3,
    parameter int DEPTH           = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    noc_vc_link_buffer_if.slave    in_link,
    noc_vc_link_buffer_if.master   out_link,
    output logic [VCHANNELS-1:0]   empty
);
    localparam int FW  = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH;
    localparam int AW  = $clog2(DEPTH);
    localparam int LGW = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

    logic [FW-1:0]        r_mem  [VCHANNELS][DEPTH];
    logic [AW:0]          r_wr   [VCHANNELS];
    logic [AW:0]          r_rd   [VCHANNELS];
    logic [LGW-1:0]       r_last;

    logic [VCHANNELS-1:0] w_full;
    logic [VCHANNELS-1:0] w_empty;
    logic [VCHANNELS-1:0] w_ready;
    logic [VCHANNELS-1:0] w_wr;
    logic [VCHANNELS-1:0] w_cand;
    logic [VCHANNELS-1:0] w_grant;
    logic [LGW-1:0]       w_next_last;
    logic [FW-1:0]        w_out;

    always_comb begin
        w_full  = '0;
        w_empty = '0;
        for (int v = 0; v < VCHANNELS; v++) begin
            w_empty[v] = (r_wr[v] == r_rd[v]);
            w_full[v]  = (r_wr[v][AW] != r_rd[v][AW]) &&
                         (r_wr[v][AW-1:0] == r_rd[v][AW-1:0]);
        end
    end

    // Ready comes from pointer state only; held low while in reset.
    assign w_ready = rst_n ? ~w_full : '0;
    assign w_wr    = in_link.valid & w_ready;
    assign w_cand  = ~w_empty & out_link.ready;

    always_comb begin
        int   idx;
        logic found;
        w_grant     = '0;
        w_next_last = r_last;
        found       = 1'b0;
        idx         = 0;
        for (int i = 1; i <= VCHANNELS; i++) begin
            idx = int'(r_last) + i;
            if (idx >= VCHANNELS)
                idx = idx - VCHANNELS;
            if (!found && w_cand[idx]) begin
                w_grant[idx] = 1'b1;
                w_next_last  = LGW'(idx);
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        w_out = '0;
        for (int v = 0; v < VCHANNELS; v++)
            if (w_grant[v])
                w_out = w_out | r_mem[v][r_rd[v][AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VCHANNELS; v++) begin
                r_wr[v] <= '0;
                r_rd[v] <= '0;
            end
            r_last <= LGW'(VCHANNELS - 1);
        end else begin
            for (int v = 0; v < VCHANNELS; v++) begin
                if (w_wr[v])
                    r_wr[v] <= r_wr[v] + 1'b1;
                if (w_grant[v])
                    r_rd[v] <= r_rd[v] + 1'b1;
            end
            if (|w_grant)
                r_last <= w_next_last;
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < VCHANNELS; v++)
            if (w_wr[v])
                r_mem[v][r_wr[v][AW-1:0]] <= in_link.flit;
    end

    assign in_link.ready  = w_ready;
    assign out_link.valid = w_grant;
    assign out_link.flit  = w_out;
    assign empty          = w_empty;

    a_in_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(in_link.valid));
endmodule
